rca_cfg_sequencer: RTL and testbench

- Issue-side execution unit for the RCA opcode (0101011, fn7 1000000).
- Accepts decoded RCA configuration instructions: fn3 = CPU_REG_CONFIG 001, GRID_MUX_CONFIG 010, IO_MUX_CONFIG 011, RESULT_MUX_CONFIG 100, IO_INP_MAP_CONFIG 101.
- Buffers them in a FIFO, drains them one per handshake onto the array configuration bus, then enforces a settle window.
- Exports cfg_idle, which issue logic uses to hold USE_FB (000) and USE_NFB (110) instructions until the array configuration is stable.

---
 rtl/rca_cfg_sequencer_if.sv | 28 ++
 rtl/rca_cfg_sequencer.sv | 123 ++++++++++++
 tb/tb_rca_cfg_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rca_cfg_sequencer_if.sv
// Issue-side and array-configuration-bus signals of the RCA configuration sequencer.
// The sequencer takes the slave modport; issue logic plus the array side take master.
interface rca_cfg_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              issue_valid;
    logic [2:0]        issue_fn3;
    logic [31:0]       issue_rs1;
    logic [31:0]       issue_rs2;
    logic              issue_ready;
    logic              illegal_inst;
    logic              cfg_valid;
    logic [2:0]        cfg_sel;
    logic [ADDR_W-1:0] cfg_addr;
    logic [31:0]       cfg_data;
    logic              cfg_ready;
    logic              cfg_idle;

    modport master (
        output issue_valid, issue_fn3, issue_rs1, issue_rs2, cfg_ready,
        input  issue_ready, illegal_inst, cfg_valid, cfg_sel, cfg_addr, cfg_data, cfg_idle
    );

    modport slave (
        input  issue_valid, issue_fn3, issue_rs1, issue_rs2, cfg_ready,
        output issue_ready, illegal_inst, cfg_valid, cfg_sel, cfg_addr, cfg_data, cfg_idle
    );
endinterface

// File: rtl/rca_cfg_sequencer.sv
// RCA config sequencer: FIFO of config instructions drained onto the array bus with a settle window.
// Define RCA_CFG_PERF_EN to add the perf_writes / perf_stall saturating counters.
module rca_cfg_sequencer #(
    parameter int DEPTH         = 4,
    parameter int ADDR_W        = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RCA_CFG_PERF_EN
    output logic [31:0]       perf_writes,
    output logic [31:0]       perf_stall,
`endif
    rca_cfg_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_MSB = PTR_W'(1) << (PTR_W - 1);

    typedef struct packed {
        logic [2:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, SETTLE} state_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty, push, pop, fn3_cfg;
    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             illegal_q;
    entry_t           out_q;

    logic unused_rs1;
    assign unused_rs1 = ^bus.issue_rs1[31:ADDR_W];

    assign full    = (wr_ptr ^ rd_ptr) == PTR_MSB;
    assign empty   = wr_ptr == rd_ptr;
    assign fn3_cfg = (bus.issue_fn3 >= 3'b001) && (bus.issue_fn3 <= 3'b101);
    // No pop-to-push bypass: a full FIFO refuses even when the head leaves this cycle.
    assign push    = bus.issue_valid && !full && fn3_cfg;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PTR_W-2:0]] <= '{sel: bus.issue_fn3, addr: bus.issue_rs1[ADDR_W-1:0],
                                        data: bus.issue_rs2};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= IDLE;
            cnt       <= '0;
            illegal_q <= 1'b0;
            out_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                out_q  <= mem[rd_ptr[PTR_W-2:0]];
            end
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            illegal_q <= bus.issue_valid && (bus.issue_fn3 == 3'b111);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (bus.cfg_ready) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else if (SETTLE_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = SETTLE;
                        cnt_nxt   = 4'(SETTLE_CYCLES);
                    end
                end
            end
            SETTLE: begin
                // A fresh push abandons the window; the next write restarts it in full.
                if (push || cnt <= 4'd1) state_nxt = IDLE;
                else                     cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.issue_ready  = !full;
    assign bus.illegal_inst = illegal_q;
    assign bus.cfg_valid    = state == WRITE;
    assign bus.cfg_sel      = out_q.sel;
    assign bus.cfg_addr     = out_q.addr;
    assign bus.cfg_data     = out_q.data;
    assign bus.cfg_idle     = (state == IDLE) && empty;

`ifdef RCA_CFG_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_writes <= '0;
            perf_stall  <= '0;
        end else begin
            if (bus.cfg_valid && bus.cfg_ready && perf_writes != '1)
                perf_writes <= perf_writes + 32'd1;
            if (bus.cfg_valid && !bus.cfg_ready && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rca_cfg_sequencer.sv
// Directed bench for rca_cfg_sequencer: bus writes are logged at negedge and compared
// against hand-computed entries, latencies and idle timing.
module tb_rca_cfg_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rca_cfg_sequencer_if #(.ADDR_W(8)) bus ();
`ifdef RCA_CFG_PERF_EN
    logic [31:0] perf_writes, perf_stall;
`endif

    rca_cfg_sequencer #(.DEPTH(4), .ADDR_W(8), .SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef RCA_CFG_PERF_EN
        .perf_writes (perf_writes),
        .perf_stall  (perf_stall),
`endif
        .bus         (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    logic [42:0] log_q[$];
    int          log_cyc[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk)
        if (rst && bus.cfg_valid && bus.cfg_ready) begin
            log_q.push_back({bus.cfg_sel, bus.cfg_addr, bus.cfg_data});
            log_cyc.push_back(cyc_cnt);
        end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        bus.issue_valid = v;
        bus.issue_fn3   = f;
        bus.issue_rs1   = a;
        bus.issue_rs2   = d;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int k = 0;
        while (!bus.cfg_idle && k < max) begin
            cyc();
            k++;
        end
        chk(tag, 64'(bus.cfg_idle), 64'd1);
    endtask

    initial begin
        int base;
        rst = 1'b0;
        drive(0, 3'd0, 32'd0, 32'd0);
        bus.cfg_ready = 1'b1;
        cyc(2);
        chk("rst_ready", 64'(bus.issue_ready), 64'd1);
        chk("rst_valid", 64'(bus.cfg_valid), 64'd0);
        chk("rst_illegal", 64'(bus.illegal_inst), 64'd0);
        chk("rst_idle", 64'(bus.cfg_idle), 64'd1);
        chk("rst_outs", 64'({bus.cfg_sel, bus.cfg_addr, bus.cfg_data}), 64'd0);
        #2 rst = 1'b1;
        cyc();

        // single write: visible two cycles after push, then two settle cycles
        drive(1, 3'b010, 32'h15, 32'hDEADBEEF);
        cyc();
        drive(0, 3'd0, 32'd0, 32'd0);
        chk("sw_n1_valid", 64'(bus.cfg_valid), 64'd0);
        chk("sw_n1_idle", 64'(bus.cfg_idle), 64'd0);
        cyc();
        chk("sw_valid", 64'(bus.cfg_valid), 64'd1);
        chk("sw_sel", 64'(bus.cfg_sel), 64'h2);
        chk("sw_addr", 64'(bus.cfg_addr), 64'h15);
        chk("sw_data", 64'(bus.cfg_data), 64'hDEADBEEF);
        cyc();
        chk("sw_drop", 64'(bus.cfg_valid), 64'd0);
        chk("sw_settle1", 64'(bus.cfg_idle), 64'd0);
        cyc();
        chk("sw_settle2", 64'(bus.cfg_idle), 64'd0);
        cyc();
        chk("sw_idle", 64'(bus.cfg_idle), 64'd1);
        chk("sw_count", 64'(log_q.size()), 64'd1);

        // backpressure: 5 accepted (1 in output reg + 4 stored), 6th refused
        base = log_q.size();
        bus.cfg_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 3'b001, 32'h20 + i, 32'h100 + i);
            chk($sformatf("bp_ready%0d", i), 64'(bus.issue_ready), (i < 5) ? 64'd1 : 64'd0);
            cyc();
        end
        drive(0, 3'd0, 32'd0, 32'd0);
        chk("bp_hold", 64'(bus.cfg_data), 64'h100);
        bus.cfg_ready = 1'b1;
        cyc(8);
        chk("bp_count", 64'(log_q.size()), 64'(base + 5));
        for (int k = 0; k < 5 && base + k < log_q.size(); k++) begin
            chk($sformatf("bp_entry%0d", k), 64'(log_q[base+k]),
                64'({3'b001, 8'(8'h20 + k), 32'(32'h100 + k)}));
            chk($sformatf("bp_b2b%0d", k), 64'(log_cyc[base+k] - log_cyc[base]), 64'(k));
        end
        wait_idle(10, "bp_idle");

        // illegal fn3 111 and non-config fn3 000
        base = log_q.size();
        drive(1, 3'b111, 32'h33, 32'h33);
        cyc();
        drive(0, 3'd0, 32'd0, 32'd0);
        chk("ill_pulse", 64'(bus.illegal_inst), 64'd1);
        cyc();
        chk("ill_clear", 64'(bus.illegal_inst), 64'd0);
        drive(1, 3'b000, 32'h34, 32'h34);
        chk("use_fb_ready", 64'(bus.issue_ready), 64'd1);
        cyc();
        drive(0, 3'd0, 32'd0, 32'd0);
        chk("use_fb_idle", 64'(bus.cfg_idle), 64'd1);
        cyc(3);
        chk("nocfg_idle", 64'(bus.cfg_idle), 64'd1);
        chk("nocfg_count", 64'(log_q.size()), 64'(base));

        // settle interrupted by a push
        drive(1, 3'b011, 32'h44, 32'hA5A50001);
        cyc();
        drive(0, 3'd0, 32'd0, 32'd0);
        cyc(2);
        chk("si_settle", 64'(bus.cfg_idle), 64'd0);
        drive(1, 3'b100, 32'h46, 32'h00000002);
        cyc();
        drive(0, 3'd0, 32'd0, 32'd0);
        chk("si_back_idle", 64'(bus.cfg_valid), 64'd0);
        cyc();
        chk("si_valid", 64'(bus.cfg_valid), 64'd1);
        chk("si_data", 64'(bus.cfg_data), 64'h2);
        cyc();
        chk("si_s1", 64'(bus.cfg_idle), 64'd0);
        cyc();
        chk("si_s2", 64'(bus.cfg_idle), 64'd0);
        cyc();
        chk("si_idle", 64'(bus.cfg_idle), 64'd1);
        chk("si_count", 64'(log_q.size()), 64'(base + 2));

        // async reset mid-write with 3 entries queued
        bus.cfg_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'b101, 32'h60 + i, 32'h200 + i);
            cyc();
        end
        drive(0, 3'd0, 32'd0, 32'd0);
        chk("ar_pre_valid", 64'(bus.cfg_valid), 64'd1);
        base = log_q.size();
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.cfg_valid), 64'd0);
        chk("ar_ready", 64'(bus.issue_ready), 64'd1);
        chk("ar_idle", 64'(bus.cfg_idle), 64'd1);
        chk("ar_outs", 64'({bus.cfg_sel, bus.cfg_addr, bus.cfg_data}), 64'd0);
        #2 rst = 1'b1;
        bus.cfg_ready = 1'b1;
        cyc(6);
        chk("ar_no_stale", 64'(log_q.size()), 64'(base));
        chk("ar_idle_after", 64'(bus.cfg_idle), 64'd1);

        // three writes with two stall cycles
`ifdef RCA_CFG_PERF_EN
        chk("perf_rst_w", 64'(perf_writes), 64'd0);
        chk("perf_rst_s", 64'(perf_stall), 64'd0);
`endif
        bus.cfg_ready = 1'b0;
        drive(1, 3'b001, 32'h70, 32'h300);
        cyc();
        drive(1, 3'b010, 32'h71, 32'h301);
        cyc();
        drive(1, 3'b011, 32'h72, 32'h302);
        cyc();
        drive(0, 3'd0, 32'd0, 32'd0);
        cyc();
        bus.cfg_ready = 1'b1;
        cyc(5);
        chk("pf_count", 64'(log_q.size()), 64'(base + 3));
        if (log_q.size() == base + 3) begin
            chk("pf_e0", 64'(log_q[base]),   64'({3'b001, 8'h70, 32'h300}));
            chk("pf_e1", 64'(log_q[base+1]), 64'({3'b010, 8'h71, 32'h301}));
            chk("pf_e2", 64'(log_q[base+2]), 64'({3'b011, 8'h72, 32'h302}));
        end
`ifdef RCA_CFG_PERF_EN
        chk("perf_writes", 64'(perf_writes), 64'd3);
        chk("perf_stall", 64'(perf_stall), 64'd2);
`endif
        wait_idle(10, "pf_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
